// File: rtl/sitcp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// sitcp_tx_arbiter
//
// Shares the SiTCP TCP transmit FIFO write port between N_SRC byte-stream
// requesters. Ownership is round-robin and frame-granular: a granted source
// keeps the port until it hands over a byte qualified by its LAST flag. If the
// connection drops (or a close is requested) mid-frame, the rest of that frame
// is accepted and discarded (DRAIN). A close request seen while idle is
// acknowledged with a CLOSE_REQ/CLOSE_ACK handshake.
//
// Optional feature, macro SITCP_TX_ARB_HEADER_EN: inserts an HDR state that
// writes one tag byte {4'hA, owner[3:0]} ahead of every frame.
//
// Ports:
//   clk_i            system clock (SiTCP core domain)
//   rstn_i           synchronous reset, active low
//   sitcp_rst_i      SiTCP soft reset, same effect as rstn_i = 0
//   main_open_ack_i  TCP connection established
//   close_req_i      close request from the core
//   close_ack_o      close acknowledge to the core (registered)
//   tx_full_i        core TX FIFO almost full
//   tx_wr_o          TX FIFO write enable (one pulse per byte)
//   tx_data_o        TX FIFO write data
//   src_valid_i      per-source byte valid
//   src_data_i       per-source byte, source i on [8i+7:8i]
//   src_last_i       per-source last-byte-of-frame flag
//   src_ready_o      per-source byte accepted (combinational, never from valid)
//   grant_o          one-hot current owner, zero when none
//   active_o         frame in progress (HDR, XFER or DRAIN)
//   drop_cnt_o       bytes discarded in DRAIN, saturating
// -----------------------------------------------------------------------------
module sitcp_tx_arbiter #(
  parameter int N_SRC = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               sitcp_rst_i,
  input  logic               main_open_ack_i,
  input  logic               close_req_i,
  output logic               close_ack_o,
  input  logic               tx_full_i,
  output logic               tx_wr_o,
  output logic [7:0]         tx_data_o,
  input  logic [N_SRC-1:0]   src_valid_i,
  input  logic [8*N_SRC-1:0] src_data_i,
  input  logic [N_SRC-1:0]   src_last_i,
  output logic [N_SRC-1:0]   src_ready_o,
  output logic [N_SRC-1:0]   grant_o,
  output logic               active_o,
  output logic [15:0]        drop_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_XFER,
    ST_DRAIN,
    ST_CLOSING
  } state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   gidx_q;
  logic [N_SRC-1:0]   grant_q;
  logic               tx_wr_q;
  logic [7:0]         tx_data_q;
  logic               close_ack_q;
  logic [15:0]        drop_cnt_q;

  logic               rst_req;
  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   ptr_d;
  logic [15:0]        drop_cnt_d;
  logic [N_SRC-1:0]   src_ready;
  logic               cur_valid;
  logic               cur_last;
  logic [7:0]         cur_data;
  logic               fire;
  logic               abort;

  // Either reset source has identical effect.
  assign rst_req = !rstn_i || sitcp_rst_i;

  // Round-robin search starting at ptr_q: first valid index wins.
  // NOTE: every signal assigned in always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % N_SRC);
      if (!pick_vld && src_valid_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign ptr_d      = (pick_idx == PTR_W'(N_SRC - 1)) ? '0 : pick_idx + PTR_W'(1);
  assign drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;

  // Ready depends only on registered state, the owner and TX_FULL. It is held
  // low while a reset is being applied so no byte is lost into a reset edge.
  always_comb begin
    src_ready = '0;
    if (!rst_req) begin
      unique case (state_q)
        ST_XFER:  src_ready[gidx_q] = !tx_full_i;
        ST_DRAIN: src_ready[gidx_q] = 1'b1;
        default:  src_ready = '0;
      endcase
    end
  end

  assign cur_valid = src_valid_i[gidx_q];
  assign cur_last  = src_last_i[gidx_q];
  assign cur_data  = src_data_i[{gidx_q, 3'b000} +: 8];
  assign fire      = cur_valid && src_ready[gidx_q];
  assign abort     = !main_open_ack_i || close_req_i;

`ifdef SITCP_TX_ARB_HEADER_EN
  logic [3:0] tag_idx;
  assign tag_idx = 4'(gidx_q);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clk_i) begin
    if (rst_req) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      tx_wr_q     <= 1'b0;
      tx_data_q   <= 8'h00;
      close_ack_q <= 1'b0;
      drop_cnt_q  <= 16'h0000;
    end else begin
      tx_wr_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // Close outranks new grants.
          if (close_req_i) begin
            state_q     <= ST_CLOSING;
            close_ack_q <= 1'b1;
          end else if (main_open_ack_i && pick_vld) begin
            gidx_q  <= pick_idx;
            grant_q <= {{(N_SRC-1){1'b0}}, 1'b1} << pick_idx;
            ptr_q   <= ptr_d;
`ifdef SITCP_TX_ARB_HEADER_EN
            state_q <= ST_HDR;
`else
            state_q <= ST_XFER;
`endif
          end
        end
`ifdef SITCP_TX_ARB_HEADER_EN
        ST_HDR: begin
          if (abort) begin
            state_q <= ST_DRAIN;
          end else if (!tx_full_i) begin
            tx_wr_q   <= 1'b1;
            tx_data_q <= {4'hA, tag_idx};
            state_q   <= ST_XFER;
          end
        end
`endif
        ST_XFER: begin
          // A byte accepted on the abort edge is still written.
          if (fire) begin
            tx_wr_q   <= 1'b1;
            tx_data_q <= cur_data;
          end
          // A completed frame returns to IDLE even if abort is seen on the
          // same edge; there is nothing left to drain.
          if (fire && cur_last) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
          end else if (abort) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fire) begin
            drop_cnt_q <= drop_cnt_d;
            if (cur_last) begin
              state_q <= ST_IDLE;
              grant_q <= '0;
            end
          end
        end
        ST_CLOSING: begin
          close_ack_q <= close_req_i;
          if (!close_req_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign src_ready_o = src_ready;
  assign grant_o     = grant_q;
  assign tx_wr_o     = tx_wr_q;
  assign tx_data_o   = tx_data_q;
  assign close_ack_o = close_ack_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign active_o    = state_q inside {ST_HDR, ST_XFER, ST_DRAIN};

endmodule

// File: tb/tb_sitcp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sitcp_tx_arbiter
//
// Directed bench for sitcp_tx_arbiter in its default build (no header tag).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or shortly after it. A monitor collects every TX FIFO write and every new
// grant so whole frames can be compared against hand-written byte lists.
// -----------------------------------------------------------------------------
module tb_sitcp_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn, sitcp_rst, open, close_req, tx_full;
  logic         v [N];
  logic [7:0]   d [N];
  logic         l [N];
  logic [N-1:0] src_valid, src_last;
  logic [8*N-1:0] src_data;

  logic         close_ack, tx_wr, active;
  logic [7:0]   tx_data;
  logic [N-1:0] src_ready, grant;
  logic [15:0]  drop_cnt;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_valid[i]       = v[i];
      src_last[i]        = l[i];
      src_data[8*i +: 8] = d[i];
    end
  end

  sitcp_tx_arbiter #(.N_SRC(N), .PTR_W(2)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .sitcp_rst_i    (sitcp_rst),
    .main_open_ack_i(open),
    .close_req_i    (close_req),
    .close_ack_o    (close_ack),
    .tx_full_i      (tx_full),
    .tx_wr_o        (tx_wr),
    .tx_data_o      (tx_data),
    .src_valid_i    (src_valid),
    .src_data_i     (src_data),
    .src_last_i     (src_last),
    .src_ready_o    (src_ready),
    .grant_o        (grant),
    .active_o       (active),
    .drop_cnt_o     (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: TX writes with their cycle stamp, and each grant as it appears.
  int           cyc = 0;
  logic [7:0]   wr_q [$];
  int           wr_cyc [$];
  int           hs_cyc [$];
  logic [N-1:0] gnt_log [$];
  logic [N-1:0] gnt_prev = '0;
  logic [7:0]   exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_wr === 1'b1) begin
      wr_q.push_back(tx_data);
      wr_cyc.push_back(cyc);
    end
    if (grant != '0 && gnt_prev == '0) gnt_log.push_back(grant);
    gnt_prev = grant;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    wr_q.delete(); wr_cyc.delete(); hs_cyc.delete(); gnt_log.delete(); exp_q.delete();
  endtask

  // Compare collected writes against exp_q.
  task automatic check_wr(input string tag);
    check({tag, "_cnt"}, wr_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("%s_b%0d", tag, k), (k < wr_q.size()) ? {24'h0, wr_q[k]} : 32'hDEAD, exp_q[k]);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tx_wr"},   tx_wr,     0);
    check({tag, "_tx_data"}, tx_data,   0);
    check({tag, "_grant"},   grant,     0);
    check({tag, "_active"},  active,    0);
    check({tag, "_drop"},    drop_cnt,  0);
    check({tag, "_ack"},     close_ack, 0);
    check({tag, "_ready"},   src_ready, 0);
  endtask

  // Present one frame from source s: bytes base, base+step, ...; last on byte n-1.
  // Call just after a falling edge; returns just after a falling edge.
  task automatic send_frame(input int s, input logic [7:0] base, input logic [7:0] step, input int n);
    for (int k = 0; k < n; k++) begin
      bit seen = 1'b0;
      v[s] = 1'b1;
      d[s] = base + 8'(k) * step;
      l[s] = (k == n - 1);
      for (int w = 0; w < 200 && !seen; w++) begin
        #2;
        if (src_ready[s]) begin
          seen = 1'b1;
          hs_cyc.push_back(cyc + 1);
        end
        @(negedge clk);
      end
      if (!seen) begin
        check($sformatf("hs_timeout_src%0d", s), seen, 1);
        v[s] = 1'b0; l[s] = 1'b0;
        return;
      end
    end
    v[s] = 1'b0;
    l[s] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; sitcp_rst = 1'b0; open = 1'b0; close_req = 1'b0; tx_full = 1'b0;
    for (int i = 0; i < N; i++) begin v[i] = 1'b0; d[i] = 8'h00; l[i] = 1'b0; end

    // ---- reset state, ready held low even with a valid request ----
    repeat (2) @(negedge clk);
    v[0] = 1'b1; open = 1'b1;
    #1;
    check_reset("por");
    @(negedge clk);
    v[0] = 1'b0;
    rstn = 1'b1;

    // ---- open: source 0 sends 11 22 33 ----
    @(negedge clk);
    clear_logs();
    send_frame(0, 8'h11, 8'h11, 3);
    repeat (2) @(negedge clk);
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_wr("open");
    check("open_gnt_cnt", gnt_log.size(), 1);
    check("open_gnt", (gnt_log.size() > 0) ? {28'h0, gnt_log[0]} : 32'hDEAD, 4'b0001);
    check("open_gnt_after", grant, 0);
    check("open_active_after", active, 0);
    for (int k = 0; k < 3; k++)
      check($sformatf("open_lat%0d", k),
            (k < wr_cyc.size()) ? wr_cyc[k] : -1, (k < hs_cyc.size()) ? hs_cyc[k] : -2);

    // ---- round-robin: sources 0,1,3 each send two 2-byte frames ----
    pulse_reset();
    clear_logs();
    fork
      begin send_frame(0, 8'h00, 8'h01, 2); send_frame(0, 8'h02, 8'h01, 2); end
      begin send_frame(1, 8'h10, 8'h01, 2); send_frame(1, 8'h12, 8'h01, 2); end
      begin send_frame(3, 8'h30, 8'h01, 2); send_frame(3, 8'h32, 8'h01, 2); end
    join
    repeat (2) @(negedge clk);
    exp_q = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h30, 8'h31,
              8'h02, 8'h03, 8'h12, 8'h13, 8'h32, 8'h33};
    check_wr("rr");
    begin
      logic [N-1:0] exp_g [6];
      exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
      check("rr_gnt_cnt", gnt_log.size(), 6);
      for (int k = 0; k < 6; k++)
        check($sformatf("rr_gnt%0d", k), (k < gnt_log.size()) ? {28'h0, gnt_log[k]} : 32'hDEAD, exp_g[k]);
    end

    // ---- back-pressure: TX_FULL for 5 cycles after 2 bytes of a 6-byte frame ----
    clear_logs();
    fork
      send_frame(2, 8'h50, 8'h01, 6);
      begin
        int w = 0;
        while (wr_q.size() < 2 && w < 100) begin @(negedge clk); #1; w++; end
        if (w >= 100) check("bp_wait", wr_q.size(), 2);
        tx_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
          #1;
          check($sformatf("bp_ready%0d", k), src_ready[2], 0);
          @(negedge clk); #1;
          check($sformatf("bp_wr%0d", k), tx_wr, 0);
        end
        tx_full = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    exp_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    check_wr("bp");

    // ---- drop: connection lost after 2 bytes of a 10-byte frame ----
    clear_logs();
    fork
      send_frame(1, 8'h60, 8'h01, 10);
      begin
        int w = 0;
        // First write visible means byte 1 is on the bus; it is the last
        // one transferred with the connection still open.
        while (wr_q.size() < 1 && w < 100) begin @(negedge clk); #1; w++; end
        if (w >= 100) check("drop_wait", wr_q.size(), 1);
        open = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    exp_q = '{8'h60, 8'h61};
    check_wr("drop");
    check("drop_cnt", drop_cnt, 8);
    check("drop_active", active, 0);
    v[2] = 1'b1; d[2] = 8'hEE; l[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("drop_nogrant%0d", k), grant, 0);
    end
    v[2] = 1'b0; l[2] = 1'b0;
    open = 1'b1;
    @(negedge clk);
    clear_logs();
    send_frame(3, 8'h70, 8'h01, 2);
    repeat (2) @(negedge clk);
    exp_q = '{8'h70, 8'h71};
    check_wr("reopen");

    // ---- close while idle with a pending request ----
    close_req = 1'b1;
    v[1] = 1'b1; d[1] = 8'h80; l[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("close_ack%0d", k), close_ack, 1);
      check($sformatf("close_gnt%0d", k), grant, 0);
    end
    close_req = 1'b0;
    @(negedge clk);
    check("close_ack_fall", close_ack, 0);
    check("close_gnt_idle", grant, 0);
    @(negedge clk);
    check("close_regrant", grant, 4'b0010);

    // ---- RSTn mid-XFER (pointer is 2 here), then first grant ----
    rstn = 1'b0;
    v[1] = 1'b0;
    v[0] = 1'b1; d[0] = 8'h90;
    v[3] = 1'b1; d[3] = 8'hB0;
    @(negedge clk);
    check_reset("rstn");
    rstn = 1'b1;
    @(negedge clk);
    check("rstn_first_grant", grant, 4'b0001);

    // ---- SITCP_RST mid-XFER (pointer is 1 here), then first grant ----
    @(negedge clk);
    sitcp_rst = 1'b1;
    @(negedge clk);
    check_reset("srst");
    sitcp_rst = 1'b0;
    @(negedge clk);
    check("srst_first_grant", grant, 4'b0001);

    v[0] = 1'b0; v[3] = 1'b0;
    pulse_reset();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
